// File: rtl/spine_router_param.sv
// Parametrised spine switch: per-input FIFOs, header-based routing to leaf or
// inter-group ports, per-output round-robin arbitration, valid/ready on every link.
module spine_router_param #(
  parameter int GROUP_ID   = 1,
  parameter int NUM_GROUPS = 8,
  parameter int NUM_LEAF   = 4,
  parameter int DWIDTH     = 16,
  parameter int GID_W      = 4,
  parameter int LEAF_W     = 2,
  parameter int FIFO_DEPTH = 8,
  localparam int P = NUM_LEAF + NUM_GROUPS - 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [P*DWIDTH-1:0] in_data,
  input  logic [P-1:0]        in_valid,
  output logic [P-1:0]        in_ready,
  output logic [P*DWIDTH-1:0] out_data,
  output logic [P-1:0]        out_valid,
  input  logic [P-1:0]        out_ready,
  output logic [15:0]         drop_count
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int PW = (P > 1) ? $clog2(P) : 1;

  logic [DWIDTH-1:0] fifo_mem [P][FIFO_DEPTH];
  logic [AW-1:0]     rd_ptr   [P];
  logic [AW-1:0]     wr_ptr   [P];
  logic [CW-1:0]     fifo_cnt [P];

  logic [P-1:0]      push;
  logic [P-1:0]      pop;
  logic [P-1:0]      head_valid;
  logic [P-1:0]      head_ok;
  logic [P-1:0]      head_drop;
  logic [DWIDTH-1:0] head_data [P];
  logic [PW-1:0]     head_port [P];

  logic [P-1:0]      can_load;
  logic [P-1:0]      grant_any;
  logic [PW-1:0]     grant_src [P];
  logic [PW-1:0]     rr        [P];
  logic [DWIDTH-1:0] out_reg   [P];

  logic [15:0]       drop_inc;
  logic [16:0]       drop_sum;

  // Ready comes only from the registered occupancy, so a full FIFO refuses
  // even when its head leaves in the same cycle.
  always_comb begin
    for (int p = 0; p < P; p++) begin
      in_ready[p] = !reset && (fifo_cnt[p] != CW'(FIFO_DEPTH));
    end
    push = in_valid & in_ready;
  end

  // Decode every FIFO head into a target port or an invalid-destination drop.
  always_comb begin
    for (int p = 0; p < P; p++) begin
      int dg;
      int dl;
      dg = int'(head_data_raw(p));
      dl = int'(fifo_mem[p][rd_ptr[p]][DWIDTH-GID_W-1 -: LEAF_W]);
      head_data[p]  = fifo_mem[p][rd_ptr[p]];
      head_valid[p] = (fifo_cnt[p] != '0);
      head_port[p]  = '0;
      head_ok[p]    = 1'b0;
      head_drop[p]  = 1'b0;
      if (dg == GROUP_ID && dl < NUM_LEAF) begin
        head_ok[p]   = head_valid[p];
        head_port[p] = PW'(dl);
      end else if (dg >= 1 && dg <= NUM_GROUPS && dg != GROUP_ID) begin
        head_ok[p]   = head_valid[p];
        head_port[p] = PW'(NUM_LEAF + ((dg < GROUP_ID) ? dg - 1 : dg - 2));
      end else begin
        head_drop[p] = head_valid[p];
      end
    end
  end

  function automatic logic [GID_W-1:0] head_data_raw(input int p);
    return fifo_mem[p][rd_ptr[p]][DWIDTH-1 -: GID_W];
  endfunction

  // Per-output round-robin search starting at rr[o]; only runs when the
  // output register is free to load this cycle.
  always_comb begin
    for (int o = 0; o < P; o++) begin
      can_load[o]  = !out_valid[o] || out_ready[o];
      grant_any[o] = 1'b0;
      grant_src[o] = '0;
      for (int off = 0; off < P; off++) begin
        int idx;
        idx = (int'(rr[o]) + off) % P;
        if (can_load[o] && !grant_any[o] && head_ok[idx] && head_port[idx] == PW'(o)) begin
          grant_any[o] = 1'b1;
          grant_src[o] = PW'(idx);
        end
      end
    end
  end

  always_comb begin
    pop = head_drop;
    for (int o = 0; o < P; o++) begin
      if (grant_any[o]) begin
        pop[grant_src[o]] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int p = 0; p < P; p++) begin
        rd_ptr[p]   <= '0;
        wr_ptr[p]   <= '0;
        fifo_cnt[p] <= '0;
      end
    end else begin
      for (int p = 0; p < P; p++) begin
        if (push[p]) begin
          wr_ptr[p] <= wr_ptr[p] + AW'(1);
        end
        if (pop[p]) begin
          rd_ptr[p] <= rd_ptr[p] + AW'(1);
        end
        fifo_cnt[p] <= fifo_cnt[p] + CW'(push[p]) - CW'(pop[p]);
      end
    end
  end

  // Storage needs no reset: occupancy and pointers decide what is visible.
  always_ff @(posedge clk) begin
    for (int p = 0; p < P; p++) begin
      if (push[p]) begin
        fifo_mem[p][wr_ptr[p]] <= in_data[p*DWIDTH +: DWIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= '0;
      for (int o = 0; o < P; o++) begin
        out_reg[o] <= '0;
        rr[o]      <= '0;
      end
    end else begin
      for (int o = 0; o < P; o++) begin
        if (can_load[o]) begin
          out_valid[o] <= grant_any[o];
        end
        if (grant_any[o]) begin
          out_reg[o] <= head_data[grant_src[o]];
          rr[o]      <= (grant_src[o] == PW'(P - 1)) ? '0 : grant_src[o] + PW'(1);
        end
      end
    end
  end

  // Several inputs may drop in the same cycle, so add the whole batch.
  always_comb begin
    drop_inc = '0;
    for (int p = 0; p < P; p++) begin
      drop_inc = drop_inc + 16'(head_drop[p]);
    end
    drop_sum = {1'b0, drop_count} + {1'b0, drop_inc};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      drop_count <= '0;
    end else begin
      drop_count <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end
  end

  always_comb begin
    for (int o = 0; o < P; o++) begin
      out_data[o*DWIDTH +: DWIDTH] = out_reg[o];
    end
  end

endmodule

// File: tb/tb_spine_router_param.sv
// Bench for spine_router_param: directed route/latency, round-robin, backpressure,
// drop and reset cases plus random traffic against a queue-based scoreboard.
module tb_spine_router_param;

  localparam int GROUP_ID   = 3;
  localparam int NUM_GROUPS = 8;
  localparam int NUM_LEAF   = 3;
  localparam int DW         = 16;
  localparam int FIFO_DEPTH = 4;
  localparam int P          = NUM_LEAF + NUM_GROUPS - 1;

  logic            clk = 1'b0;
  logic            reset;
  logic [P*DW-1:0] in_data;
  logic [P-1:0]    in_valid;
  logic [P-1:0]    in_ready;
  logic [P*DW-1:0] out_data;
  logic [P-1:0]    out_valid;
  logic [P-1:0]    out_ready;
  logic [15:0]     drop_count;

  int n_vec  = 0;
  int n_miss = 0;
  int exp_drops = 0;
  logic [DW-1:0] exp_q [P*P][$];
  int rr_log[$];
  int log_port = 1;
  bit log_en = 1'b0;

  spine_router_param #(
    .GROUP_ID(GROUP_ID), .NUM_GROUPS(NUM_GROUPS), .NUM_LEAF(NUM_LEAF), .DWIDTH(DW),
    .GID_W(4), .LEAF_W(2), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  // Flit layout used by the bench: header, then source port and a sequence tag.
  function automatic logic [DW-1:0] flit(input int dg, input int dl, input int src, input int seq);
    return {4'(dg), 2'(dl), 4'(src), 6'(seq)};
  endfunction

  // Reference routing: output port index, or -1 when the flit must be dropped.
  function automatic int route(input logic [DW-1:0] f);
    int dg;
    int dl;
    dg = int'(f[15:12]);
    dl = int'(f[11:10]);
    if (dg == GROUP_ID) return (dl < NUM_LEAF) ? dl : -1;
    if (dg >= 1 && dg <= NUM_GROUPS) return NUM_LEAF + ((dg < GROUP_ID) ? dg - 1 : dg - 2);
    return -1;
  endfunction

  function automatic int pending();
    int n = 0;
    for (int i = 0; i < P*P; i++) n += exp_q[i].size();
    return n;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic [P*DW-1:0] d, input logic [P-1:0] v, input logic [P-1:0] r);
    @(posedge clk);
    #1;
    in_data   = d;
    in_valid  = v;
    out_ready = r;
  endtask

  task automatic waitDrain(input int budget);
    int c = 0;
    while (pending() != 0 && c < budget) begin
      @(posedge clk);
      c++;
    end
    checkOutput("drain_pending", 32'(pending()), 0);
  endtask

  task automatic scoreboardPop(input int o, input logic [DW-1:0] d);
    int src;
    int key;
    logic [DW-1:0] e;
    src = int'(d[9:6]);
    checkOutput("src_in_range", 32'(src < P), 1);
    if (src < P) begin
      key = o * P + src;
      checkOutput($sformatf("sb_expected_p%0d", o), 32'(exp_q[key].size() != 0), 1);
      if (exp_q[key].size() != 0) begin
        e = exp_q[key].pop_front();
        checkOutput($sformatf("route_data_p%0d", o), 32'(d), 32'(e));
      end
      if (log_en && o == log_port) rr_log.push_back(src);
    end
  endtask

  // Monitor: consumes every output transfer, checks hold-while-stalled, and
  // records every accepted input flit into the scoreboard.
  initial begin : monitor
    logic [P-1:0]  stall;
    logic [DW-1:0] stall_data [P];
    logic [DW-1:0] d;
    int r;
    stall = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        stall = '0;
      end else begin
        for (int o = 0; o < P; o++) begin
          d = out_data[o*DW +: DW];
          if (stall[o]) checkOutput($sformatf("hold_p%0d", o), {15'b0, out_valid[o], d}, {15'b0, 1'b1, stall_data[o]});
          if (out_valid[o] && out_ready[o]) scoreboardPop(o, d);
          stall[o] = out_valid[o] && !out_ready[o];
          stall_data[o] = d;
        end
        for (int p = 0; p < P; p++) begin
          if (in_valid[p] && in_ready[p]) begin
            d = in_data[p*DW +: DW];
            r = route(d);
            if (r < 0) exp_drops++;
            else exp_q[r*P + p].push_back(d);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    int tin  [8] = '{0, 3, 1, 2, 4, 5, 2, 9};
    int tdg  [8] = '{5, 3, 1, 2, 8, 3, 3, 4};
    int tdl  [8] = '{1, 2, 0, 3, 0, 0, 2, 1};
    int texp [8] = '{6, 2, 3, 4, 9, 0, 2, 5};
    int rr_src [3] = '{0, 2, 7};
    int seq [P];
    logic [P*DW-1:0] d;
    logic [P-1:0] v;
    logic [P-1:0] rdy;
    int acc;
    int dg;

    foreach (seq[i]) seq[i] = 0;
    reset = 1'b1; in_data = '0; in_valid = '0; out_ready = '1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_in_ready", 32'(in_ready), 0);
    checkOutput("reset_out_valid", 32'(out_valid), 0);
    checkOutput("reset_out_data", 32'(|out_data), 0);
    @(posedge clk); #1; reset = 1'b0;
    @(negedge clk);
    checkOutput("post_reset_in_ready", 32'(in_ready), 32'((1 << P) - 1));
    checkOutput("post_reset_drop", 32'(drop_count), 0);

    // Single routes, including the lower/upper group split and a U-turn.
    for (int c = 0; c < 8; c++) begin
      d = '0; v = '0;
      d[tin[c]*DW +: DW] = flit(tdg[c], tdl[c], tin[c], c);
      v[tin[c]] = 1'b1;
      applyStimulus(d, v, '1);
      applyStimulus('0, '0, '1);
      @(negedge clk);
      checkOutput($sformatf("latency1_quiet_%0d", c), 32'(out_valid), 0);
      @(negedge clk);
      checkOutput($sformatf("latency2_port_%0d", c), 32'(out_valid), 32'(1 << texp[c]));
    end
    waitDrain(20);

    // Backpressure: one flit in the output register plus a full FIFO.
    rdy = '1; rdy[2] = 1'b0;
    acc = 0;
    for (int k = 0; k < 20; k++) begin
      d = '0;
      d[DW-1:0] = flit(3, 2, 0, 10 + k);
      applyStimulus(d, 10'b1, rdy);
      @(negedge clk);
      if (!in_ready[0]) break;
      acc++;
    end
    checkOutput("bp_accepted", 32'(acc), 32'(FIFO_DEPTH + 1));
    applyStimulus(d, 10'b1, rdy);
    @(negedge clk);
    checkOutput("bp_ready_held_low", 32'(in_ready[0]), 0);
    checkOutput("bp_out_valid", 32'(out_valid[2]), 1);
    applyStimulus('0, '0, '1);
    waitDrain(40);

    // Invalid destinations: group 0, group 9, local leaf 3, group 15.
    d = '0;
    d[0*DW +: DW] = flit(0, 0, 0, 40);
    d[1*DW +: DW] = flit(9, 0, 1, 40);
    d[2*DW +: DW] = flit(3, 3, 2, 40);
    d[3*DW +: DW] = flit(15, 1, 3, 40);
    applyStimulus(d, 10'b1111, '1);
    applyStimulus('0, '0, '1);
    @(negedge clk);
    checkOutput("drop_before_pop", 32'(drop_count), 0);
    checkOutput("drop_in_ready", 32'(in_ready), 32'((1 << P) - 1));
    @(negedge clk);
    checkOutput("drop_after_pop", 32'(drop_count), 4);
    checkOutput("drop_no_output", 32'(out_valid), 0);

    // Reset with traffic buffered; port 4 -> port 1 moves rr[1] beforehand.
    d = '0;
    d[0*DW +: DW] = flit(5, 0, 0, 50);
    d[1*DW +: DW] = flit(1, 0, 1, 50);
    d[2*DW +: DW] = flit(3, 0, 2, 50);
    d[3*DW +: DW] = flit(3, 2, 3, 50);
    d[4*DW +: DW] = flit(3, 1, 4, 50);
    applyStimulus(d, 10'b11111, '0);
    applyStimulus(d, 10'b11111, '0);
    applyStimulus('0, '0, '0);
    applyStimulus('0, '0, '0);
    reset = 1'b1;
    foreach (exp_q[i]) exp_q[i].delete();
    exp_drops = 0;
    @(negedge clk);
    checkOutput("mid_reset_in_ready", 32'(in_ready), 0);
    @(negedge clk);
    checkOutput("mid_reset_out_valid", 32'(out_valid), 0);
    checkOutput("mid_reset_drop", 32'(drop_count), 0);
    @(posedge clk); #1; reset = 1'b0; out_ready = '1;
    @(negedge clk);
    checkOutput("after_reset_quiet", 32'(out_valid), 0);
    checkOutput("after_reset_in_ready", 32'(in_ready), 32'((1 << P) - 1));
    @(negedge clk);
    checkOutput("after_reset_still_quiet", 32'(out_valid), 0);

    // Round-robin into leaf 1 from ports 0, 2 and 7, starting from rr = 0.
    rr_log.delete(); log_port = 1; log_en = 1'b1;
    rdy = '1; rdy[1] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      d = '0;
      foreach (rr_src[i]) d[rr_src[i]*DW +: DW] = flit(3, 1, rr_src[i], 60 + k);
      applyStimulus(d, 10'b0010000101, rdy);
    end
    applyStimulus('0, '0, rdy);
    applyStimulus('0, '0, rdy);
    applyStimulus('0, '0, '1);
    for (int t = 0; t < 40 && rr_log.size() < 9; t++) @(negedge clk);
    checkOutput("rr_count", 32'(rr_log.size()), 9);
    for (int i = 0; i < 9 && i < rr_log.size(); i++)
      checkOutput($sformatf("rr_order_%0d", i), 32'(rr_log[i]), 32'(rr_src[i % 3]));
    log_en = 1'b0;
    waitDrain(20);

    // Random traffic with random downstream stalls.
    for (int cyc = 0; cyc < 1500; cyc++) begin
      d = '0; v = '0;
      for (int p = 0; p < P; p++) begin
        rdy[p] = ($urandom_range(0, 9) < 7);
        if ($urandom_range(0, 1) == 1) begin
          dg = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(1, NUM_GROUPS));
          v[p] = 1'b1;
          d[p*DW +: DW] = flit(dg, int'($urandom_range(0, 3)), p, seq[p]);
          seq[p]++;
        end
      end
      applyStimulus(d, v, rdy);
    end
    applyStimulus('0, '0, '1);
    waitDrain(400);
    repeat (8) @(posedge clk);
    @(negedge clk);
    checkOutput("final_drop_count", 32'(drop_count), 32'(exp_drops));
    checkOutput("final_idle", 32'(out_valid), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
